// File: rtl/ldtu_gain_select.sv
// LiTe-DTU gain selection: forwards gain_10 and switches to gain_1 around saturated samples.
// Optional LDTU_GS_FORCE_EN adds force_g01/force_g10 overrides at the output register.
module ldtu_gain_select #(
  parameter int unsigned Nbits_12    = 12,
  parameter int unsigned PRE_SAMPLES = 4,
  parameter int unsigned TAIL_SHORT  = 8,
  parameter int unsigned TAIL_LONG   = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic [Nbits_12-1:0] DATA_gain_01,
  input  logic [Nbits_12-1:0] DATA_gain_10,
  input  logic [Nbits_12-1:0] SATURATION_value,
  input  logic                win_sel,
`ifdef LDTU_GS_FORCE_EN
  input  logic                force_g01,
  input  logic                force_g10,
`endif
  output logic [Nbits_12:0]   DATA_gain,
  output logic                SeuError
);

  logic [Nbits_12-1:0] r_d01 [0:PRE_SAMPLES];
  logic [Nbits_12-1:0] r_d10 [0:PRE_SAMPLES];
  logic [CNT_W-1:0]    r_cnt;
  logic [Nbits_12:0]   r_data_gain;

  logic                w_sat;
  logic [CNT_W-1:0]    w_reload;
  logic                w_sel_g01;

  assign w_sat    = (DATA_gain_10 >= SATURATION_value);
  assign w_reload = win_sel ? CNT_W'(PRE_SAMPLES + TAIL_LONG)
                            : CNT_W'(PRE_SAMPLES + TAIL_SHORT);

`ifdef LDTU_GS_FORCE_EN
  // Forces act only on the output mux; the counter keeps tracking the window.
  assign w_sel_g01 = force_g01 ? 1'b1 :
                     force_g10 ? 1'b0 : (r_cnt != '0);
`else
  assign w_sel_g01 = (r_cnt != '0);
`endif

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i <= PRE_SAMPLES; i++) begin
        r_d01[i] <= '0;
        r_d10[i] <= '0;
      end
    end else begin
      r_d01[0] <= DATA_gain_01;
      r_d10[0] <= DATA_gain_10;
      for (int unsigned i = 1; i <= PRE_SAMPLES; i++) begin
        r_d01[i] <= r_d01[i-1];
        r_d10[i] <= r_d10[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (w_sat) begin
      r_cnt <= w_reload;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_data_gain <= '0;
    end else if (w_sel_g01) begin
      r_data_gain <= {1'b1, r_d01[PRE_SAMPLES]};
    end else begin
      r_data_gain <= {1'b0, r_d10[PRE_SAMPLES]};
    end
  end

  assign DATA_gain = r_data_gain;
  assign SeuError  = 1'b0;

endmodule

// File: tb/tb_ldtu_gain_select.sv
// Self-checking bench for ldtu_gain_select against a sample-indexed window model.
// Define LDTU_GS_FORCE_EN for both files to exercise the force inputs.
module tb_ldtu_gain_select;
  localparam int PRE        = 4;
  localparam int TAIL_SHORT = 8;
  localparam int TAIL_LONG  = 16;

  logic        CLK;
  logic        rst_b;
  logic [11:0] DATA_gain_01;
  logic [11:0] DATA_gain_10;
  logic [11:0] SATURATION_value;
  logic        win_sel;
  logic        force_g01;
  logic        force_g10;
  logic [12:0] DATA_gain;
  logic        SeuError;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [11:0] g01;
    logic [11:0] g10;
    bit          sat;
    bit          sel;
    bit          f01;
    bit          f10;
  } sample_t;

  sample_t hist[$];

  ldtu_gain_select #(
    .Nbits_12(12), .PRE_SAMPLES(PRE), .TAIL_SHORT(TAIL_SHORT),
    .TAIL_LONG(TAIL_LONG), .CNT_W(5)
  ) dut (
    .CLK(CLK),
    .rst_b(rst_b),
    .DATA_gain_01(DATA_gain_01),
    .DATA_gain_10(DATA_gain_10),
    .SATURATION_value(SATURATION_value),
    .win_sel(win_sel),
`ifdef LDTU_GS_FORCE_EN
    .force_g01(force_g01),
    .force_g10(force_g10),
`endif
    .DATA_gain(DATA_gain),
    .SeuError(SeuError)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tail_of(input bit sel);
    return sel ? TAIL_LONG : TAIL_SHORT;
  endfunction

  // Output at edge e (1-based since release) carries sample e-PRE-2. It is gain_1 when the
  // latest saturated sample j seen before that edge still covers it: k <= j + TAIL(j) - 1.
  function automatic logic [12:0] expected_out();
    int  e, k, j_last;
    bit  flag;
    logic [11:0] data;
    e      = hist.size();
    k      = e - PRE - 2;
    j_last = -1;
    for (int j = k + PRE; j >= 0; j--) begin
      if (hist[j].sat) begin
        j_last = j;
        break;
      end
    end
    flag = (j_last >= 0) && (k <= j_last + tail_of(hist[j_last].sel) - 1);
    if (hist[e-1].f01)      flag = 1'b1;
    else if (hist[e-1].f10) flag = 1'b0;
    if (k < 0)     data = '0;
    else if (flag) data = hist[k].g01;
    else           data = hist[k].g10;
    return {flag, data};
  endfunction

  task automatic step(input logic [11:0] g10, input logic [11:0] g01, input bit sel,
                      input string tag);
    sample_t s;
    DATA_gain_10 = g10;
    DATA_gain_01 = g01;
    win_sel      = sel;
    @(posedge CLK);
    s.g01 = g01;
    s.g10 = g10;
    s.sat = (g10 >= SATURATION_value);
    s.sel = sel;
    s.f01 = force_g01;
    s.f10 = force_g10;
    hist.push_back(s);
    #1;
    check(tag, DATA_gain, expected_out());
  endtask

  // Asynchronous assertion between edges, held for n edges, released between edges.
  task automatic do_reset(input int n);
    #2 rst_b = 1'b0;
    #1 check("reset_async", DATA_gain, 13'h0);
    repeat (n) begin
      @(posedge CLK);
      #1 check("reset_hold", DATA_gain, 13'h0);
    end
    rst_b = 1'b1;
    hist.delete();
  endtask

  initial begin
    rst_b = 1'b0;
    DATA_gain_10 = 12'd100;
    DATA_gain_01 = 12'd10;
    SATURATION_value = 12'd4000;
    win_sel = 1'b0;
    force_g01 = 1'b0;
    force_g10 = 1'b0;

    repeat (3) begin
      @(posedge CLK);
      #1 check("reset_init", DATA_gain, 13'h0);
    end
    check("seu", {31'b0, SeuError}, 32'd0);
    rst_b = 1'b1;
    hist.delete();

    for (int i = 0; i < 12; i++) step(12'd100, 12'd10, 1'b0, "steady");
    check("steady_val", DATA_gain, {1'b0, 12'd100});

    // Single trigger, short window
    do_reset(2);
    for (int i = 0; i < 40; i++)
      step((i == 20) ? 12'd4095 : 12'(i), 12'($urandom_range(0, 4095)), 1'b0, "single");

    // Retrigger inside the active window
    do_reset(2);
    for (int i = 0; i < 45; i++)
      step((i == 20 || i == 25) ? 12'd4095 : 12'(i), 12'($urandom_range(0, 4095)), 1'b0, "retrig");

    // Long window, exact threshold, then one below
    do_reset(2);
    for (int i = 0; i < 45; i++)
      step((i == 20) ? 12'd4000 : 12'(i), 12'($urandom_range(0, 4095)), 1'b1, "long_eq");
    do_reset(2);
    for (int i = 0; i < 45; i++)
      step((i == 20) ? 12'd3999 : 12'(i), 12'($urandom_range(0, 4095)), 1'b1, "long_below");

    // Abort mid-window; nothing saturates afterwards
    do_reset(2);
    for (int i = 0; i < 12; i++)
      step((i == 5) ? 12'd4095 : 12'(i), 12'($urandom_range(0, 4095)), 1'b0, "pre_abort");
    check("abort_flag_set", {31'b0, DATA_gain[12]}, 32'd1);
    do_reset(2);
    for (int i = 0; i < 30; i++)
      step(12'($urandom_range(0, 3999)), 12'($urandom_range(0, 4095)), 1'b0, "post_abort");
    check("post_abort_flag", {31'b0, DATA_gain[12]}, 32'd0);

    // Threshold 0: everything saturates, including the zero-filled pre-window
    do_reset(1);
    SATURATION_value = 12'd0;
    for (int i = 0; i < 20; i++)
      step(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), "thr0");

    // Threshold 4095: only full scale triggers
    do_reset(1);
    SATURATION_value = 12'd4095;
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 19) == 0) ? 12'd4095 : 12'($urandom_range(4080, 4094)),
           12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), "thr4095");

    // Random traffic with win_sel toggling mid-window
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) SATURATION_value = 12'($urandom_range(3500, 4095));
      step(($urandom_range(0, 24) == 0) ? 12'($urandom_range(3500, 4095)) : 12'($urandom_range(0, 3499)),
           12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), "random");
    end

`ifdef LDTU_GS_FORCE_EN
    do_reset(1);
    SATURATION_value = 12'd4000;
    for (int i = 0; i < 10; i++) step(12'd50, 12'd7, 1'b0, "force_idle");
    force_g01 = 1'b1;
    step(12'd50, 12'd7, 1'b0, "force_g01_on");
    check("force_g01_flag", {31'b0, DATA_gain[12]}, 32'd1);
    force_g01 = 1'b0;
    step(12'd50, 12'd7, 1'b0, "force_g01_off");
    check("force_g01_rel", {31'b0, DATA_gain[12]}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      force_g01 = ($urandom_range(0, 7) == 0);
      force_g10 = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 19) == 0) ? 12'd4095 : 12'($urandom_range(0, 3999)),
           12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), "force_rand");
    end
    force_g01 = 1'b0;
    force_g10 = 1'b0;
`endif

    check("seu_end", {31'b0, SeuError}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
